// File: rtl/npu_test_sequencer.sv
// NPU self-test sequencer: launches enabled suite channels in index order, collects
// per-test results, and enforces a per-suite inactivity watchdog plus a global timeout.
module npu_test_sequencer #(
    parameter int NUM_SUITES     = 5,
    parameter int CNT_W          = 16,
    parameter int TMO_W          = 32,
    parameter int SUITE_TIMEOUT  = 20000,
    parameter int GLOBAL_TIMEOUT = 1000000,
    localparam int CUR_W         = (NUM_SUITES > 1) ? $clog2(NUM_SUITES) : 1
) (
    input  logic                  test_clk,
    input  logic                  test_rst,
    input  logic                  start,
    input  logic [NUM_SUITES-1:0] suite_enable,
    output logic [NUM_SUITES-1:0] suite_start,
    output logic [NUM_SUITES-1:0] suite_abort,
    input  logic [NUM_SUITES-1:0] res_valid,
    input  logic [NUM_SUITES-1:0] res_pass,
    input  logic [NUM_SUITES-1:0] suite_done,
    output logic                  busy,
    output logic                  done,
    output logic                  all_passed,
    output logic                  timed_out,
    output logic [CUR_W-1:0]      cur_suite,
    output logic [CNT_W-1:0]      tests_run,
    output logic [CNT_W-1:0]      tests_passed,
    output logic [CNT_W-1:0]      tests_failed,
    output logic [NUM_SUITES-1:0] suite_fail_mask
);

    localparam logic [TMO_W-1:0] WD_LAST  = TMO_W'(SUITE_TIMEOUT - 1);
    localparam logic [TMO_W-1:0] G_LAST   = TMO_W'(GLOBAL_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LAUNCH,
        S_RUN,
        S_NEXT,
        S_DONE
    } state_t;

    state_t state, state_next;

    logic [TMO_W-1:0]      wdog;
    logic [TMO_W-1:0]      gcnt;
    logic [CUR_W-1:0]      first_idx;
    logic [CUR_W-1:0]      next_idx;
    logic [CUR_W-1:0]      new_idx;
    logic                  any_en;
    logic                  any_above;
    logic                  ch_valid;
    logic                  ch_pass;
    logic                  ch_done;
    logic                  wd_expire;
    logic                  g_expire;
    logic                  clear_run;
    logic                  load_idx;
    logic                  count_evt;
    logic                  evt_pass;
    logic                  wd_clear;
    logic                  wd_inc;
    logic                  g_inc;
    logic                  set_tmo;
    logic                  abort_now;
    logic [NUM_SUITES-1:0] cur_onehot;

    assign ch_valid   = res_valid[cur_suite];
    assign ch_pass    = res_pass[cur_suite];
    assign ch_done    = suite_done[cur_suite];
    assign wd_expire  = (wdog == WD_LAST);
    assign g_expire   = (gcnt == G_LAST);
    assign cur_onehot = NUM_SUITES'(1) << cur_suite;

    // Lowest enabled index overall, and lowest enabled index above the active one.
    always_comb begin
        first_idx = '0;
        next_idx  = '0;
        any_en    = 1'b0;
        any_above = 1'b0;
        for (int i = NUM_SUITES - 1; i >= 0; i--) begin
            if (suite_enable[i]) begin
                first_idx = CUR_W'(i);
                any_en    = 1'b1;
                if (CUR_W'(i) > cur_suite) begin
                    next_idx  = CUR_W'(i);
                    any_above = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge test_clk or posedge test_rst) begin
        if (test_rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Global timeout overrides whatever transition the state would otherwise take.
    always_comb begin
        state_next = state;
        clear_run  = 1'b0;
        load_idx   = 1'b0;
        new_idx    = first_idx;
        count_evt  = 1'b0;
        evt_pass   = 1'b0;
        wd_clear   = 1'b0;
        wd_inc     = 1'b0;
        g_inc      = 1'b0;
        set_tmo    = 1'b0;
        abort_now  = 1'b0;
        case (state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    clear_run = 1'b1;
                    if (any_en) begin
                        load_idx   = 1'b1;
                        new_idx    = first_idx;
                        state_next = S_LAUNCH;
                    end else begin
                        state_next = S_DONE;
                    end
                end
            end
            S_LAUNCH: begin
                wd_clear   = 1'b1;
                g_inc      = 1'b1;
                state_next = S_RUN;
                if (g_expire) begin
                    set_tmo    = 1'b1;
                    state_next = S_DONE;
                end
            end
            S_RUN: begin
                g_inc = 1'b1;
                if (ch_valid) begin
                    count_evt = 1'b1;
                    evt_pass  = ch_pass;
                    wd_clear  = 1'b1;
                end
                if (ch_done) begin
                    state_next = S_NEXT;
                end else if (!ch_valid && wd_expire) begin
                    abort_now  = 1'b1;
                    count_evt  = 1'b1;
                    evt_pass   = 1'b0;
                    state_next = S_NEXT;
                end else if (!ch_valid) begin
                    wd_inc = 1'b1;
                end
                if (g_expire) begin
                    set_tmo    = 1'b1;
                    abort_now  = 1'b1;
                    state_next = S_DONE;
                end
            end
            S_NEXT: begin
                g_inc = 1'b1;
                if (any_above) begin
                    load_idx   = 1'b1;
                    new_idx    = next_idx;
                    state_next = S_LAUNCH;
                end else begin
                    state_next = S_DONE;
                end
                if (g_expire) begin
                    load_idx   = 1'b0;
                    set_tmo    = 1'b1;
                    state_next = S_DONE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge test_clk or posedge test_rst) begin
        if (test_rst) begin
            cur_suite <= '0;
            wdog      <= '0;
            gcnt      <= '0;
        end else begin
            if (load_idx) begin
                cur_suite <= new_idx;
            end
            if (wd_clear) begin
                wdog <= '0;
            end else if (wd_inc) begin
                wdog <= wdog + 1'b1;
            end
            if (clear_run) begin
                gcnt <= '0;
            end else if (g_inc) begin
                gcnt <= gcnt + 1'b1;
            end
        end
    end

    // Each counter saturates on its own, so a full tests_run never stalls pass/fail.
    always_ff @(posedge test_clk or posedge test_rst) begin
        if (test_rst) begin
            tests_run       <= '0;
            tests_passed    <= '0;
            tests_failed    <= '0;
            suite_fail_mask <= '0;
            timed_out       <= 1'b0;
        end else if (clear_run) begin
            tests_run       <= '0;
            tests_passed    <= '0;
            tests_failed    <= '0;
            suite_fail_mask <= '0;
            timed_out       <= 1'b0;
        end else begin
            if (count_evt) begin
                if (tests_run != CNT_MAX) begin
                    tests_run <= tests_run + 1'b1;
                end
                if (evt_pass) begin
                    if (tests_passed != CNT_MAX) begin
                        tests_passed <= tests_passed + 1'b1;
                    end
                end else begin
                    if (tests_failed != CNT_MAX) begin
                        tests_failed <= tests_failed + 1'b1;
                    end
                    suite_fail_mask <= suite_fail_mask | cur_onehot;
                end
            end
            if (set_tmo) begin
                timed_out <= 1'b1;
            end
        end
    end

    assign suite_start = (state == S_LAUNCH) ? cur_onehot : '0;
    assign suite_abort = abort_now ? cur_onehot : '0;
    assign busy        = (state == S_LAUNCH) || (state == S_RUN) || (state == S_NEXT);
    assign done        = (state == S_DONE);
    assign all_passed  = done && (tests_failed == '0) && (tests_run != '0) && !timed_out;

endmodule

// File: tb/tb_npu_test_sequencer.sv
// Directed bench for npu_test_sequencer; a second instance with 2-bit counters shares
// the stimulus so saturation can be observed alongside the full-width results.
module tb_npu_test_sequencer;

    logic       test_clk = 1'b0;
    logic       test_rst = 1'b1;
    logic       start = 1'b0;
    logic [4:0] suite_enable = '0;
    logic [4:0] res_valid = '0;
    logic [4:0] res_pass = '0;
    logic [4:0] suite_done = '0;

    logic [4:0]  suite_start, suite_abort, suite_fail_mask;
    logic        busy, done, all_passed, timed_out;
    logic [2:0]  cur_suite;
    logic [15:0] tests_run, tests_passed, tests_failed;

    logic [4:0]  sat_start, sat_abort, sat_mask;
    logic        sat_busy, sat_done, sat_all_passed, sat_timed_out;
    logic [2:0]  sat_cur;
    logic [1:0]  sat_run, sat_passed, sat_failed;

    int checks = 0;
    int errors = 0;

    always #5 test_clk = ~test_clk;

    npu_test_sequencer #(
        .NUM_SUITES(5), .CNT_W(16), .TMO_W(32), .SUITE_TIMEOUT(100), .GLOBAL_TIMEOUT(500)
    ) dut (
        .test_clk(test_clk), .test_rst(test_rst), .start(start), .suite_enable(suite_enable),
        .suite_start(suite_start), .suite_abort(suite_abort), .res_valid(res_valid),
        .res_pass(res_pass), .suite_done(suite_done), .busy(busy), .done(done),
        .all_passed(all_passed), .timed_out(timed_out), .cur_suite(cur_suite),
        .tests_run(tests_run), .tests_passed(tests_passed), .tests_failed(tests_failed),
        .suite_fail_mask(suite_fail_mask)
    );

    npu_test_sequencer #(
        .NUM_SUITES(5), .CNT_W(2), .TMO_W(32), .SUITE_TIMEOUT(100), .GLOBAL_TIMEOUT(500)
    ) dut_sat (
        .test_clk(test_clk), .test_rst(test_rst), .start(start), .suite_enable(suite_enable),
        .suite_start(sat_start), .suite_abort(sat_abort), .res_valid(res_valid),
        .res_pass(res_pass), .suite_done(suite_done), .busy(sat_busy), .done(sat_done),
        .all_passed(sat_all_passed), .timed_out(sat_timed_out), .cur_suite(sat_cur),
        .tests_run(sat_run), .tests_passed(sat_passed), .tests_failed(sat_failed),
        .suite_fail_mask(sat_mask)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
        end
    endtask

    // One clock cycle: drive inputs mid-cycle, then settle so outputs can be sampled.
    task automatic applyStimulus(input logic [4:0] v, input logic [4:0] p,
                                 input logic [4:0] d, input logic st);
        @(negedge test_clk);
        res_valid  = v;
        res_pass   = p;
        suite_done = d;
        start      = st;
        #1;
    endtask

    task automatic runSuite(input int idx, input int npass, input int nfail);
        logic [4:0] bit_sel;
        bit_sel = 5'(1 << idx);
        applyStimulus('0, '0, '0, 1'b0);
        checkOutput($sformatf("launch%0d", idx), suite_start, bit_sel);
        checkOutput($sformatf("cur%0d", idx), cur_suite, idx);
        for (int i = 0; i < npass; i++) applyStimulus(bit_sel, bit_sel, '0, 1'b0);
        for (int i = 0; i < nfail; i++) applyStimulus(bit_sel, '0, '0, 1'b0);
        applyStimulus('0, '0, bit_sel, 1'b0);
        applyStimulus('0, '0, '0, 1'b0);
        checkOutput($sformatf("next_quiet%0d", idx), suite_start, 0);
    endtask

    initial begin
        int  k;
        bit  seen;

        #12;
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_done", done, 0);
        checkOutput("rst_start", suite_start, 0);
        checkOutput("rst_run", tests_run, 0);
        checkOutput("rst_allp", all_passed, 0);
        @(negedge test_clk);
        test_rst = 1'b0;

        $display("[TB] test 1: all suites, 3 passes each");
        suite_enable = 5'b11111;
        applyStimulus('0, '0, '0, 1'b1);
        for (int s = 0; s < 5; s++) runSuite(s, 3, 0);
        applyStimulus('0, '0, '0, 1'b0);
        checkOutput("t1_done", done, 1);
        checkOutput("t1_run", tests_run, 15);
        checkOutput("t1_passed", tests_passed, 15);
        checkOutput("t1_failed", tests_failed, 0);
        checkOutput("t1_allp", all_passed, 1);
        checkOutput("t1_mask", suite_fail_mask, 0);
        checkOutput("t1_sat_run", sat_run, 3);
        checkOutput("t1_sat_passed", sat_passed, 3);

        $display("[TB] test 2: sparse enable 10100");
        suite_enable = 5'b10100;
        applyStimulus('0, '0, '0, 1'b1);
        runSuite(2, 1, 0);
        runSuite(4, 1, 0);
        applyStimulus('0, '0, '0, 1'b0);
        checkOutput("t2_done", done, 1);
        checkOutput("t2_run", tests_run, 2);
        checkOutput("t2_mask", suite_fail_mask, 0);
        checkOutput("t2_allp", all_passed, 1);

        $display("[TB] test 3: suite watchdog");
        suite_enable = 5'b00110;
        applyStimulus('0, '0, '0, 1'b1);
        applyStimulus('0, '0, '0, 1'b0);
        checkOutput("t3_launch1", suite_start, 5'b00010);
        applyStimulus(5'b00010, 5'b00010, '0, 1'b0);
        k = 0;
        seen = 0;
        for (int i = 0; i < 200 && !seen; i++) begin
            applyStimulus('0, '0, '0, 1'b0);
            k++;
            if (suite_abort != 0) seen = 1;
        end
        checkOutput("t3_seen", seen, 1);
        checkOutput("t3_delay", k, 100);
        checkOutput("t3_abort_bits", suite_abort, 5'b00010);
        applyStimulus('0, '0, '0, 1'b0);
        checkOutput("t3_next_quiet", suite_start, 0);
        runSuite(2, 0, 0);
        applyStimulus('0, '0, '0, 1'b0);
        checkOutput("t3_done", done, 1);
        checkOutput("t3_failed", tests_failed, 1);
        checkOutput("t3_run", tests_run, 2);
        checkOutput("t3_mask", suite_fail_mask, 5'b00010);
        checkOutput("t3_allp", all_passed, 0);

        $display("[TB] test 4: global timeout");
        suite_enable = 5'b00001;
        applyStimulus('0, '0, '0, 1'b1);
        applyStimulus('0, '0, '0, 1'b0);
        checkOutput("t4_launch0", suite_start, 5'b00001);
        k = 0;
        seen = 0;
        for (int i = 0; i < 1000 && !seen; i++) begin
            applyStimulus(5'b00001, 5'b00001, '0, 1'b0);
            k++;
            if (suite_abort != 0) seen = 1;
        end
        checkOutput("t4_seen", seen, 1);
        checkOutput("t4_busy_cycles", k + 1, 500);
        checkOutput("t4_abort_bits", suite_abort, 5'b00001);
        applyStimulus('0, '0, '0, 1'b0);
        checkOutput("t4_done", done, 1);
        checkOutput("t4_tmo", timed_out, 1);
        checkOutput("t4_allp", all_passed, 0);
        checkOutput("t4_run", tests_run, 499);
        checkOutput("t4_sat_run", sat_run, 3);

        $display("[TB] test 5: fail+done same cycle, start while busy");
        suite_enable = 5'b00011;
        applyStimulus('0, '0, '0, 1'b1);
        applyStimulus('0, '0, '0, 1'b0);
        checkOutput("t5_launch0", suite_start, 5'b00001);
        applyStimulus(5'b00001, 5'b00000, 5'b00001, 1'b1);
        applyStimulus('0, '0, '0, 1'b0);
        checkOutput("t5_next_busy", busy, 1);
        checkOutput("t5_next_cur", cur_suite, 0);
        checkOutput("t5_fail_cnt", tests_failed, 1);
        applyStimulus('0, '0, '0, 1'b0);
        checkOutput("t5_launch1", suite_start, 5'b00010);
        applyStimulus(5'b00001, 5'b00000, '0, 1'b0);
        for (int i = 0; i < 4; i++) applyStimulus(5'b00010, '0, '0, 1'b0);
        applyStimulus('0, '0, 5'b00010, 1'b0);
        applyStimulus('0, '0, '0, 1'b0);
        applyStimulus('0, '0, '0, 1'b0);
        checkOutput("t5_done", done, 1);
        checkOutput("t5_failed", tests_failed, 5);
        checkOutput("t5_run", tests_run, 5);
        checkOutput("t5_tmo", timed_out, 0);
        checkOutput("t5_mask", suite_fail_mask, 5'b00011);
        checkOutput("t5_sat_failed", sat_failed, 3);
        checkOutput("t5_sat_run", sat_run, 3);

        $display("[TB] test 6: reset mid-run");
        suite_enable = 5'b11111;
        applyStimulus('0, '0, '0, 1'b1);
        for (int s = 0; s < 3; s++) runSuite(s, 1, 0);
        applyStimulus('0, '0, '0, 1'b0);
        checkOutput("t6_launch3", suite_start, 5'b01000);
        applyStimulus(5'b01000, 5'b01000, '0, 1'b0);
        @(negedge test_clk);
        res_valid = '0;
        res_pass  = '0;
        test_rst  = 1'b1;
        #1;
        checkOutput("t6_busy", busy, 0);
        checkOutput("t6_abort", suite_abort, 0);
        checkOutput("t6_run", tests_run, 0);
        checkOutput("t6_cur", cur_suite, 0);
        checkOutput("t6_mask", suite_fail_mask, 0);
        @(negedge test_clk);
        test_rst = 1'b0;
        applyStimulus('0, '0, '0, 1'b1);
        for (int s = 0; s < 5; s++) runSuite(s, 1, 0);
        applyStimulus('0, '0, '0, 1'b0);
        checkOutput("t6_done", done, 1);
        checkOutput("t6_run_after", tests_run, 5);
        checkOutput("t6_allp", all_passed, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
